// File: rtl/crack_pkg.sv
// Shared types and helpers for the crack-core arbiter.
// Holds the arbiter state enum, bus widths and the winner priority encoder.
package crack_pkg;

  localparam int KEY_W  = 24;
  localparam int ADDR_W = 8;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    ARM,
    WAIT,
    COPY,
    DONE_FOUND,
    DONE_NONE
  } arb_state_t;

  // Lowest set bit wins; scanned high to low so the last hit is the lowest.
  function automatic logic [1:0] first_set(input logic [3:0] v);
    first_set = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) first_set = 2'(i);
    end
  endfunction

endpackage

// File: rtl/pt_copier.sv
// Copies a length-prefixed plaintext from the winning core into the result
// memory. Ports: clk, rst, start (pulse), src_rddata in; src_addr, dst_addr,
// dst_wrdata, dst_wren, done out. Source reads have one cycle of latency.
module pt_copier
  import crack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] src_rddata,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [BYTE_W-1:0] dst_wrdata,
  output logic              dst_wren,
  output logic              done
);

  logic              busy;
  // One bit wider than the address so a 255-byte payload cannot wrap.
  logic [ADDR_W:0]   rd;
  logic [BYTE_W-1:0] len_q;
  logic [BYTE_W-1:0] len;

  assign src_addr   = rd[ADDR_W-1:0];
  assign dst_wren   = busy && (rd != '0);
  assign dst_addr   = dst_wren ? rd[ADDR_W-1:0] - ADDR_W'(1) : '0;
  assign dst_wrdata = src_rddata;

  // The length byte is in flight on the first write; use it directly.
  assign len  = (rd == (ADDR_W+1)'(1)) ? src_rddata : len_q;
  assign done = dst_wren && (rd == {1'b0, len} + (ADDR_W+1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      rd    <= '0;
      len_q <= '0;
    end else if (start) begin
      busy <= 1'b1;
      rd   <= '0;
    end else if (busy) begin
      if (rd == (ADDR_W+1)'(1)) len_q <= src_rddata;
      if (done) begin
        busy <= 1'b0;
        rd   <= '0;
      end else begin
        rd <= rd + (ADDR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/crack_arbiter.sv
// Arbiter over N_CORES crack cores: broadcast start, pick the first
// (lowest-index) core reporting a key, latch it and copy its plaintext out.
// Ports: clk, rst, en/rdy/key/key_valid (top side), core_* (core side),
// pt_addr/pt_wrdata/pt_wren (result memory). Optional macro
// CRACK_ARB_TIMEOUT_EN adds a WAIT timeout and the timed_out output.
module crack_arbiter
  import crack_pkg::*;
#(
  parameter int N_CORES = 2,
  parameter int KEY_W   = 24
`ifdef CRACK_ARB_TIMEOUT_EN
  ,
  parameter logic [31:0] TIMEOUT_CYC = 32'hFFFF_FFFF
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  output logic                       rdy,
  output logic [KEY_W-1:0]           key,
  output logic                       key_valid,
  output logic                       core_en,
  input  logic [N_CORES-1:0]         core_rdy,
  input  logic [N_CORES*KEY_W-1:0]   core_key,
  input  logic [N_CORES-1:0]         core_key_valid,
  output logic [ADDR_W-1:0]          core_pt_addr,
  input  logic [N_CORES*BYTE_W-1:0]  core_pt_rddata,
  output logic [ADDR_W-1:0]          pt_addr,
  output logic [BYTE_W-1:0]          pt_wrdata,
  output logic                       pt_wren
`ifdef CRACK_ARB_TIMEOUT_EN
  ,
  output logic                       timed_out
`endif
);

  localparam int CW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  if (N_CORES < 1 || N_CORES > 4) begin : g_bad_cores
    $error("crack_arbiter: N_CORES must be 1..4");
  end

  arb_state_t  state;
  logic [CW-1:0] win_idx;
  logic [CW-1:0] win_n;
  logic [3:0]  vpad;
  logic        any_valid;
  logic        all_rdy;
  logic        tmo_hit;
  logic        copy_start;
  logic        copy_done;

  always_comb begin
    vpad = '0;
    vpad[N_CORES-1:0] = core_key_valid;
  end

  assign any_valid  = |core_key_valid;
  assign all_rdy    = &core_rdy;
  assign win_n      = CW'(first_set(vpad));
  assign copy_start = (state == WAIT) && any_valid;

`ifdef CRACK_ARB_TIMEOUT_EN
  logic [31:0] wait_cnt;
  assign tmo_hit = (wait_cnt == TIMEOUT_CYC - 32'd1);
`else
  assign tmo_hit = 1'b0;
`endif

  pt_copier u_copier (
    .clk        (clk),
    .rst        (rst),
    .start      (copy_start),
    .src_rddata (core_pt_rddata[int'(win_idx)*BYTE_W +: BYTE_W]),
    .src_addr   (core_pt_addr),
    .dst_addr   (pt_addr),
    .dst_wrdata (pt_wrdata),
    .dst_wren   (pt_wren),
    .done       (copy_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rdy       <= 1'b1;
      key_valid <= 1'b0;
      key       <= '0;
      core_en   <= 1'b0;
      win_idx   <= '0;
`ifdef CRACK_ARB_TIMEOUT_EN
      wait_cnt  <= '0;
      timed_out <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE_FOUND, DONE_NONE: begin
          if (en) begin
            state     <= LAUNCH;
            rdy       <= 1'b0;
            key_valid <= 1'b0;
            core_en   <= 1'b1;
`ifdef CRACK_ARB_TIMEOUT_EN
            timed_out <= 1'b0;
`endif
          end
        end
        LAUNCH: begin
          state   <= ARM;
          core_en <= 1'b0;
`ifdef CRACK_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        // Cores still show rdy here while their own rdy falls.
        ARM: state <= WAIT;
        WAIT: begin
`ifdef CRACK_ARB_TIMEOUT_EN
          wait_cnt <= wait_cnt + 32'd1;
`endif
          if (any_valid) begin
            state   <= COPY;
            win_idx <= win_n;
            key     <= core_key[int'(win_n)*KEY_W +: KEY_W];
          end else if (all_rdy || tmo_hit) begin
            state <= DONE_NONE;
            rdy   <= 1'b1;
`ifdef CRACK_ARB_TIMEOUT_EN
            timed_out <= tmo_hit;
`endif
          end
        end
        COPY: begin
          if (copy_done) begin
            state     <= DONE_FOUND;
            rdy       <= 1'b1;
            key_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crack_arbiter.sv
// Directed self-checking bench for crack_arbiter with two modelled cores.
// Each scenario task drives cores/en and checks results inline.
module tb_crack_arbiter;

  localparam int NC = 2;
  localparam int KW = 24;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           rdy;
  logic [KW-1:0]  key;
  logic           key_valid;
  logic           core_en;
  logic [NC-1:0]  core_rdy = '0;
  logic [NC*KW-1:0] core_key = '0;
  logic [NC-1:0]  core_key_valid = '0;
  logic [7:0]     core_pt_addr;
  logic [NC*8-1:0] core_pt_rddata = '0;
  logic [7:0]     pt_addr;
  logic [7:0]     pt_wrdata;
  logic           pt_wren;
`ifdef CRACK_ARB_TIMEOUT_EN
  logic           timed_out;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] cmem [NC][256];
  logic [7:0] wr_mem [256];
  int         run_cnt = 0;
  int         order_err = 0;
  logic [7:0] last_addr = '0;

  crack_arbiter #(
    .N_CORES (NC),
    .KEY_W   (KW)
`ifdef CRACK_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (32'd100)
`endif
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .rdy            (rdy),
    .key            (key),
    .key_valid      (key_valid),
    .core_en        (core_en),
    .core_rdy       (core_rdy),
    .core_key       (core_key),
    .core_key_valid (core_key_valid),
    .core_pt_addr   (core_pt_addr),
    .core_pt_rddata (core_pt_rddata),
    .pt_addr        (pt_addr),
    .pt_wrdata      (pt_wrdata),
    .pt_wren        (pt_wren)
`ifdef CRACK_ARB_TIMEOUT_EN
    ,
    .timed_out      (timed_out)
`endif
  );

  always #5 clk = ~clk;

  // Core plaintext memories: one-cycle read latency.
  always @(posedge clk) begin
    for (int i = 0; i < NC; i++)
      core_pt_rddata[i*8 +: 8] <= cmem[i][core_pt_addr];
  end

  // Result-memory logger; a launch starts a new run.
  always @(negedge clk) begin
    if (core_en) begin
      run_cnt = 0;
      order_err = 0;
    end
    if (pt_wren) begin
      if (run_cnt >= 256 || int'(pt_addr) != run_cnt) order_err++;
      wr_mem[pt_addr] = pt_wrdata;
      last_addr = pt_addr;
      run_cnt++;
    end
  end

  task automatic launch();
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rdy !== 1'b1) begin
      errors++; $display("FAIL reset_rdy: got %b want 1", rdy);
    end
    checks++;
    if (key_valid !== 1'b0 || key !== 24'h0) begin
      errors++;
      $display("FAIL reset_key: got kv=%b key=%h want 0/000000", key_valid, key);
    end
    checks++;
    if (core_en !== 1'b0 || pt_wren !== 1'b0) begin
      errors++;
      $display("FAIL reset_en: got core_en=%b pt_wren=%b want 0/0", core_en, pt_wren);
    end
    checks++;
    if (pt_addr !== 8'h00 || core_pt_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_addr: got %h/%h want 00/00", pt_addr, core_pt_addr);
    end
    rst = 1'b0;
  endtask

  task automatic load_hello();
    logic [7:0] h [6];
    h = '{8'h05, 8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    for (int i = 0; i < 256; i++) begin
      cmem[0][i] = 8'h33;
      cmem[1][i] = 8'hEE;
    end
    for (int i = 0; i < 6; i++) cmem[1][i] = h[i];
  endtask

  task automatic test_hello(input string tag);
    bit ok;
    logic [7:0] h [6];
    h = '{8'h05, 8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    load_hello();
    core_key = {24'h1E4600, 24'hABCDEF};
    core_key_valid = 2'b00;
    core_rdy = 2'b00;
    launch();
    checks++;
    if (core_en !== 1'b1 || rdy !== 1'b0 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_launch: got en=%b rdy=%b kv=%b want 1/0/0",
               tag, core_en, rdy, key_valid);
    end
    @(negedge clk);
    checks++;
    if (core_en !== 1'b0) begin
      errors++; $display("FAIL %s_arm_en: got %b want 0", tag, core_en);
    end
    repeat (3) @(negedge clk);
    core_key_valid = 2'b10;
    wait_done(100, ok);
    core_key_valid = 2'b00;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL %s_done: got timeout want rdy=1", tag);
    end
    checks++;
    if (key !== 24'h1E4600 || key_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_key: got %h kv=%b want 1e4600 kv=1", tag, key, key_valid);
    end
    checks++;
    if (run_cnt != 6 || order_err != 0) begin
      errors++;
      $display("FAIL %s_writes: got %0d order_err=%0d want 6/0", tag, run_cnt, order_err);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wr_mem[i] !== h[i]) begin
        errors++;
        $display("FAIL %s_data%0d: got %h want %h", tag, i, wr_mem[i], h[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    for (int i = 0; i < 256; i++) begin
      cmem[0][i] = 8'h00;
      cmem[1][i] = 8'h00;
    end
    cmem[0][0] = 8'h02; cmem[0][1] = 8'h41; cmem[0][2] = 8'h42;
    cmem[1][0] = 8'h01; cmem[1][1] = 8'h5A;
    core_key = {24'h000011, 24'h000010};
    launch();
    checks++;
    if (key_valid !== 1'b0) begin
      errors++; $display("FAIL sim_kv_clear: got %b want 0", key_valid);
    end
    repeat (3) @(negedge clk);
    core_key_valid = 2'b11;
    wait_done(100, ok);
    core_key_valid = 2'b00;
    checks++;
    if (!ok || key !== 24'h000010) begin
      errors++; $display("FAIL sim_key: got %h ok=%0d want 000010", key, ok);
    end
    checks++;
    if (run_cnt != 3 || wr_mem[1] !== 8'h41 || wr_mem[2] !== 8'h42) begin
      errors++;
      $display("FAIL sim_data: got n=%0d %h %h want 3 41 42", run_cnt, wr_mem[1], wr_mem[2]);
    end
  endtask

  task automatic test_none();
    bit ok;
    core_rdy = 2'b11;
    launch();
    @(negedge clk);
    @(negedge clk);
    core_rdy = 2'b00;
    repeat (4) @(negedge clk);
    checks++;
    if (rdy !== 1'b0) begin
      errors++; $display("FAIL none_early: got rdy=%b want 0", rdy);
    end
    core_rdy = 2'b11;
    wait_done(20, ok);
    checks++;
    if (!ok || key_valid !== 1'b0 || run_cnt != 0) begin
      errors++;
      $display("FAIL none_done: got ok=%0d kv=%b n=%0d want 1/0/0", ok, key_valid, run_cnt);
    end
    core_rdy = 2'b00;
  endtask

  task automatic test_len0();
    bit ok;
    cmem[1][0] = 8'h00;
    cmem[1][1] = 8'h77;
    core_key = {24'h0000AA, 24'h0000BB};
    launch();
    repeat (3) @(negedge clk);
    core_key_valid = 2'b10;
    wait_done(50, ok);
    core_key_valid = 2'b00;
    checks++;
    if (!ok || run_cnt != 1 || wr_mem[0] !== 8'h00 || key_valid !== 1'b1) begin
      errors++;
      $display("FAIL len0: got ok=%0d n=%0d d=%h kv=%b want 1/1/00/1",
               ok, run_cnt, wr_mem[0], key_valid);
    end
  endtask

  task automatic test_len255();
    bit ok;
    logic [7:0] v;
    cmem[0][0] = 8'hFF;
    for (int i = 1; i < 256; i++) begin
      v = 8'(i);
      cmem[0][i] = v ^ 8'h5A;
    end
    core_key = {24'h000002, 24'h000001};
    launch();
    repeat (3) @(negedge clk);
    core_key_valid = 2'b01;
    wait_done(600, ok);
    core_key_valid = 2'b00;
    checks++;
    if (!ok || run_cnt != 256 || order_err != 0) begin
      errors++;
      $display("FAIL len255_cnt: got ok=%0d n=%0d oe=%0d want 1/256/0", ok, run_cnt, order_err);
    end
    checks++;
    if (last_addr !== 8'hFF || wr_mem[255] !== 8'hA5 || wr_mem[0] !== 8'hFF) begin
      errors++;
      $display("FAIL len255_last: got a=%h d=%h d0=%h want ff a5 ff",
               last_addr, wr_mem[255], wr_mem[0]);
    end
  endtask

  task automatic test_reset_copy();
    int n;
    int snap;
    bit hit;
    for (int i = 0; i < 256; i++) cmem[1][i] = 8'h10;
    cmem[1][0] = 8'd10;
    core_key = {24'h0000CC, 24'h0000DD};
    launch();
    repeat (3) @(negedge clk);
    core_key_valid = 2'b10;
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pt_wren) n++;
      if (n == 3) begin
        hit = 1'b1;
        break;
      end
    end
    rst = 1'b1;
    core_key_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (!hit || pt_wren !== 1'b0 || rdy !== 1'b1 || key_valid !== 1'b0 || core_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_copy: got hit=%0d wren=%b rdy=%b kv=%b want 1/0/1/0",
               hit, pt_wren, rdy, key_valid);
    end
    rst = 1'b0;
    snap = run_cnt;
    repeat (4) @(negedge clk);
    checks++;
    if (run_cnt != snap || run_cnt != 3) begin
      errors++; $display("FAIL rst_nowrite: got %0d want 3", run_cnt);
    end
  endtask

`ifdef CRACK_ARB_TIMEOUT_EN
  task automatic test_timeout();
    core_rdy = 2'b00;
    core_key_valid = 2'b00;
    launch();
    repeat (101) @(negedge clk);
    checks++;
    if (rdy !== 1'b0 || timed_out !== 1'b0) begin
      errors++; $display("FAIL tmo_early: got rdy=%b to=%b want 0/0", rdy, timed_out);
    end
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1 || timed_out !== 1'b1 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_hit: got rdy=%b to=%b kv=%b want 1/1/0", rdy, timed_out, key_valid);
    end
    core_rdy = 2'b11;
    launch();
    checks++;
    if (timed_out !== 1'b0) begin
      errors++; $display("FAIL tmo_clear: got %b want 0", timed_out);
    end
    repeat (4) @(negedge clk);
    core_rdy = 2'b00;
  endtask
`endif

  initial begin
    test_reset();
    test_hello("hello");
    test_simultaneous();
    test_none();
    test_len0();
    test_len255();
    test_reset_copy();
    test_hello("restart");
`ifdef CRACK_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
